// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter one byte at a time via tx_data/tx_send.
// Latency: write into empty FIFO with idle uart -> tx_send high 2 edges later.
// Backpressure: holds bytes while tx_busy/drain_en block; writes while full are dropped and flagged.
`timescale 1ns/1ps
module uart_tx_fifo #(
   parameter int DEPTH        = 16,
   parameter int ADDR_W       = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   input  logic              drain_en,
   input  logic              clr_flags,
   input  logic              tx_busy,
   output logic [7:0]        tx_data,
   output logic              tx_send,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              send_err
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [2:0]      TMO_LIM  = 3'(BUSY_TIMEOUT);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   state_t            state_q;
   logic [2:0]        tmo_q;
   logic [7:0]        tx_data_q;
   logic              tx_send_q;
   logic              overflow_q, send_err_q;
   logic              full_w, empty_w;
   logic              wr_acc, ovf_set, pop, err_set;

   // Occupancy flags come only from the count, never from pointer equality.
   assign full_w  = (count_q == FULL_CNT);
   assign empty_w = (count_q == '0);

   // Accept/drop decision, pop decision and next pointer/count values.
   always_comb begin
      wr_acc   = wr_en && !full_w;
      ovf_set  = wr_en && full_w;
      pop      = (state_q == IDLE) && !empty_w && drain_en && !tx_busy;
      err_set  = (state_q == WAIT_BUSY) && !tx_busy && ((tmo_q + 3'd1) == TMO_LIM);
      wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (wr_acc && !pop) begin
         count_d = count_q + (ADDR_W+1)'(1);
      end else if (!wr_acc && pop) begin
         count_d = count_q - (ADDR_W+1)'(1);
      end
   end

   // Storage array; contents need no reset because the pointers and count do.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pointers, occupancy and the sticky overflow flag (set beats clear).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= ovf_set | (overflow_q & ~clr_flags);
      end
   end

   // Drain FSM: pops the head in IDLE, pulses tx_send, then tracks the uart frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_send_q  <= 1'b0;
         send_err_q <= 1'b0;
      end else begin
         tx_send_q  <= 1'b0;
         send_err_q <= err_set | (send_err_q & ~clr_flags);
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q   <= SEND;
                  tx_data_q <= mem_q[rd_ptr_q];
                  tx_send_q <= 1'b1;
               end
            end
            SEND: begin
               state_q <= WAIT_BUSY;
               tmo_q   <= '0;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state_q <= WAIT_DONE;
               end else if (err_set) begin
                  // Byte is treated as consumed; the uart never picked it up.
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + 3'd1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_send  = tx_send_q;
   assign full     = full_w;
   assign empty    = empty_w;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign send_err = send_err_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corner sequences, randomized traffic.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
// A simple uart responder captures bytes and holds tx_busy for a frame time.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       drain_en;
   logic       clr_flags;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       send_err;

   int checks   = 0;
   int failures = 0;

   // uart responder state
   logic       uart_auto = 1'b0;
   logic       busy_man  = 1'b0;
   int         frame_len = 3;
   int         busy_cnt  = 0;
   logic       prev_send = 1'b0;
   int         proto_bad = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .BUSY_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
      .drain_en(drain_en), .clr_flags(clr_flags), .tx_busy(tx_busy),
      .tx_data(tx_data), .tx_send(tx_send), .full(full), .empty(empty),
      .count(count), .overflow(overflow), .send_err(send_err)
   );

   always #5 clk = ~clk;

   assign tx_busy = uart_auto ? (busy_cnt != 0) : busy_man;

   // Behavioural uart: latches the byte on a send request, stays busy for frame_len cycles.
   always @(posedge clk) begin
      if (tx_send && prev_send) proto_bad++;
      prev_send <= tx_send;
      if (rst) begin
         busy_cnt <= 0;
      end else if (uart_auto && tx_send) begin
         if (busy_cnt != 0) proto_bad++;
         rx_q.push_back(tx_data);
         busy_cnt <= frame_len;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic w, input logic [7:0] d, input logic drn, input logic clr);
      wr_en     = w;
      wr_data   = d;
      drain_en  = drn;
      clr_flags = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      rx_q.delete();
      exp_q.delete();
   endtask

   // Bounded wait for n captured bytes, then a few idle cycles to settle the FSM.
   task automatic wait_rx(input int n);
      for (int k = 0; k < 3000 && rx_q.size() < n; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic chk_seq(input string name);
      int bad = 0;
      chk({name, "_len"}, rx_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
         if (rx_q[k] !== exp_q[k]) bad++;
      chk({name, "_order"}, bad, 0);
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       drn;
      logic       clr;
      logic       busy;
      int         e_cnt;
      logic       e_send;
      logic [7:0] e_data;
      logic       e_err;
   } vec_t;

   vec_t tbl[17];

   initial begin
      int acc, bad, cap;
      logic w;
      logic [7:0] d;

      wr_en = 0; wr_data = 0; drain_en = 0; clr_flags = 0; rst = 1;
      do_reset();

      // reset state
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_send", tx_send, 0);
      chk("rst_data", tx_data, 8'h00);
      chk("rst_ovf", overflow, 0);
      chk("rst_err", send_err, 0);

      // ---- table: 41/42/43 with hand-driven tx_busy, then a timeout ----
      //            wr  data  drn clr busy cnt send data   err
      tbl[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b0};
      tbl[2]  = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 2, 1'b0, 8'h41, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2, 1'b0, 8'h41, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2, 1'b0, 8'h41, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b0, 8'h41, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h42, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h42, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1, 1'b0, 8'h42, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h42, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h43, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h43, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h43, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h43, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h43, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h43, 1'b1};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h43, 1'b0};
      uart_auto = 1'b0;
      for (int i = 0; i < 17; i++) begin
         busy_man = tbl[i].busy;
         cyc(tbl[i].wr, tbl[i].d, tbl[i].drn, tbl[i].clr);
         chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
         chk($sformatf("v%0d_empty", i), empty, (tbl[i].e_cnt == 0));
         chk($sformatf("v%0d_send", i), tx_send, tbl[i].e_send);
         chk($sformatf("v%0d_data", i), tx_data, tbl[i].e_data);
         chk($sformatf("v%0d_err", i), send_err, tbl[i].e_err);
      end

      // ---- fill to full, overflow, clear-vs-set, write-while-full with pop ----
      do_reset();
      uart_auto = 1'b1; frame_len = 3;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         exp_q.push_back(8'(i));
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      cyc(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("ovf_set", overflow, 1);
      chk("ovf_count", count, 16);
      cyc(1'b1, 8'hFF, 1'b0, 1'b1);
      chk("ovf_set_beats_clr", overflow, 1);
      cyc(1'b1, 8'hFE, 1'b1, 1'b0);
      chk("full_pop_count", count, 15);
      chk("full_pop_send", tx_send, 1);
      chk("full_pop_data", tx_data, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      chk("ovf_clr", overflow, 0);
      wait_rx(16);
      chk_seq("full_drain");
      chk("full_drain_empty", empty, 1);

      // ---- simultaneous write and pop at count 5 ----
      do_reset();
      uart_auto = 1'b1; frame_len = 2;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
         exp_q.push_back(8'h10 + 8'(i));
      end
      chk("five_count", count, 5);
      cyc(1'b1, 8'h15, 1'b1, 1'b0);
      exp_q.push_back(8'h15);
      chk("wr_pop_count", count, 5);
      chk("wr_pop_send", tx_send, 1);
      chk("wr_pop_data", tx_data, 8'h10);
      wait_rx(6);
      chk_seq("wr_pop_drain");

      // ---- reset during WAIT_DONE with 4 bytes still queued ----
      do_reset();
      uart_auto = 1'b0; busy_man = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("mid_pop_count", count, 4);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      busy_man = 1'b1;
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      rst = 1'b1;
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      rst = 1'b0;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_send", tx_send, 0);
      chk("mid_rst_data", tx_data, 8'h00);
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      chk("post_rst_busy_send", tx_send, 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rst_busy_count", count, 1);
      busy_man = 1'b0;
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rst_idle_send", tx_send, 1);
      chk("post_rst_idle_data", tx_data, 8'h55);
      chk("post_rst_idle_count", count, 0);

      // ---- randomized traffic, 48 bytes through the 16-entry ring ----
      do_reset();
      uart_auto = 1'b1;
      acc = 0; bad = 0;
      for (int c = 0; c < 4000 && acc < 48; c++) begin
         frame_len = int'($urandom_range(1, 6));
         w = ($urandom_range(0, 1) == 1) && ((acc - rx_q.size()) <= 15);
         d = 8'($urandom_range(0, 255));
         if (w) begin
            exp_q.push_back(d);
            acc++;
         end
         cyc(w, d, ($urandom_range(0, 3) != 0), 1'b0);
         cap = rx_q.size();
         // the byte being sent right now is popped but not yet latched by the uart
         if (!(int'(count) == acc - cap || int'(count) + 1 == acc - cap)) bad++;
         if (int'(count) > 16) bad++;
         if (empty !== (count == 0) || full !== (count == 16)) bad++;
      end
      chk("rand_accepted", acc, 48);
      chk("rand_count_track", bad, 0);
      wait_rx(48);
      chk_seq("rand_drain");
      chk("rand_end_empty", empty, 1);
      chk("rand_end_ovf", overflow, 0);
      chk("rand_end_err", send_err, 0);
      chk("uart_protocol", proto_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
